// File: rtl/gb_pkg.sv
// rtl/gb_pkg.sv - shared constants and state encoding for the Green Beret ROM loader
package gb_pkg;

  localparam int ROM_AW = 18;
  localparam logic [18:0] GB_ROM_SIZE = 19'h2C000;
  localparam int FIFO_W = 26;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE,
    ERROR
  } gb_state_t;

endpackage

// File: rtl/gb_dl_fifo.sv
// rtl/gb_dl_fifo.sv - small synchronous FIFO buffering {address, data} download entries
module gb_dl_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 26
) (
  input  logic                       clk48M,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0] CNT_ONE = 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fill;
  logic          do_push;
  logic          do_pop;

  // A pop in the same cycle frees a slot, so a push on full is still taken.
  assign do_pop  = pop & (fill != '0);
  assign do_push = push & ((fill != CNT_FULL) | do_pop);

  always_ff @(posedge clk48M or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   fill <= fill + CNT_ONE;
        2'b01:   fill <= fill - CNT_ONE;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk48M) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (fill == CNT_FULL);
  assign empty = (fill == '0);
  assign count = fill;

endmodule

// File: rtl/gb_rom_loader.sv
// rtl/gb_rom_loader.sv - filters the HPS download stream and replays it as paced ROMEN writes
module gb_rom_loader
  import gb_pkg::*;
#(
  parameter logic [18:0] ROM_SIZE   = GB_ROM_SIZE,
  parameter logic [7:0]  DL_INDEX   = 8'd0,
  parameter int          FIFO_DEPTH = 4,
  parameter int          PACE       = 2
) (
  input  logic              clk48M,
  input  logic              reset,
  input  logic              dl_download,
  input  logic [7:0]        dl_index,
  input  logic              dl_wr,
  input  logic [24:0]       dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_wait,
  output logic              ROMCL,
  output logic [ROM_AW-1:0] ROMAD,
  output logic [7:0]        ROMDT,
  output logic              ROMEN,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = (PACE > 1) ? $clog2(PACE) : 1;
  localparam logic [CW-1:0] CNT_ONE    = 1;
  localparam logic [CW-1:0] WAIT_LVL   = CW'(FIFO_DEPTH - 1);
  localparam logic [PW-1:0] PACE_LOAD  = PW'(PACE - 1);
  localparam logic [PW-1:0] PACE_ONE   = 1;
  localparam logic [18:0]   BYTE_MAX   = '1;
  localparam logic [18:0]   BYTE_ONE   = 1;
  localparam logic [24:0]   ADDR_LIMIT = {6'd0, ROM_SIZE};

  gb_state_t         state;
  gb_state_t         state_next;
  logic              dl_download_q;
  logic              dl_rise;
  logic              dl_fall;
  logic              index_ok;
  logic              start;
  logic              accept;
  logic              pop;
  logic              fifo_push;
  logic              overrun;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     fill_next;
  logic [FIFO_W-1:0] fifo_dout;
  logic [PW-1:0]     pace_cnt;
  logic [18:0]       byte_cnt;
  logic              load_err_r;

  assign ROMCL    = clk48M;
  assign load_err = load_err_r;

  assign dl_rise  = dl_download & ~dl_download_q;
  assign dl_fall  = ~dl_download & dl_download_q;
  assign index_ok = (dl_index == DL_INDEX);

  assign accept    = (state == LOAD) & dl_wr & dl_download & index_ok & (dl_addr < ADDR_LIMIT);
  assign pop       = ~fifo_empty & (pace_cnt == '0);
  assign fifo_push = accept & (~fifo_full | pop);
  assign overrun   = accept & fifo_full & ~pop;

  gb_dl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FIFO_W)
  ) u_fifo (
    .clk48M (clk48M),
    .reset  (reset),
    .push   (fifo_push),
    .din    ({dl_addr[ROM_AW-1:0], dl_data}),
    .pop    (pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // dl_wait tracks the fill level the FIFO will hold next cycle.
  always_comb begin
    fill_next = fifo_count;
    if (fifo_push) fill_next = fill_next + CNT_ONE;
    if (pop)       fill_next = fill_next - CNT_ONE;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    core_reset = 1'b1;
    load_done  = 1'b0;
    case (state)
      IDLE: begin
        if (dl_rise && index_ok) begin
          start      = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (dl_fall) state_next = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty && !ROMEN)
          state_next = ((byte_cnt == ROM_SIZE) && !load_err_r) ? DONE : ERROR;
      end
      DONE: begin
        core_reset = 1'b0;
        load_done  = 1'b1;
        if (dl_rise && index_ok) begin
          start      = 1'b1;
          state_next = LOAD;
        end
      end
      ERROR: begin
        if (dl_rise && index_ok) begin
          start      = 1'b1;
          state_next = LOAD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk48M or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      dl_download_q <= 1'b0;
      load_err_r    <= 1'b0;
      byte_cnt      <= '0;
      pace_cnt      <= '0;
      dl_wait       <= 1'b0;
      ROMAD         <= '0;
      ROMDT         <= '0;
      ROMEN         <= 1'b0;
    end else begin
      state         <= state_next;
      dl_download_q <= dl_download;
      dl_wait       <= (fill_next >= WAIT_LVL);
      ROMEN         <= pop;
      if (pop) begin
        ROMAD <= fifo_dout[FIFO_W-1:8];
        ROMDT <= fifo_dout[7:0];
      end
      if (pop)
        pace_cnt <= PACE_LOAD;
      else if (pace_cnt != '0)
        pace_cnt <= pace_cnt - PACE_ONE;
      if (start)
        load_err_r <= 1'b0;
      else if (overrun || state_next == ERROR)
        load_err_r <= 1'b1;
      if (start)
        byte_cnt <= '0;
      else if (ROMEN && byte_cnt != BYTE_MAX)
        byte_cnt <= byte_cnt + BYTE_ONE;
    end
  end

endmodule
